// File: rtl/sacc_ctrl_pkg.sv
// Shared definitions for the sacc control path: opcodes, 4-bit state codes,
// accumulator source selects and small decode helpers.
package sacc_ctrl_pkg;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_LACC = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_SACC = 4'b1111;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_LATCH  = 4'd2;
    localparam logic [3:0] ST_DECODE = 4'd3;
    localparam logic [3:0] ST_WBREG  = 4'd4;
    localparam logic [3:0] ST_EXEC   = 4'd5;
    localparam logic [3:0] ST_MEMRD  = 4'd6;
    localparam logic [3:0] ST_MEMWB  = 4'd7;
    localparam logic [3:0] ST_MEMWR  = 4'd8;
    localparam logic [3:0] ST_HALT   = 4'd9;

    localparam logic [1:0] ACC_SRC_A   = 2'b00;
    localparam logic [1:0] ACC_SRC_SUM = 2'b01;
    localparam logic [1:0] ACC_SRC_MDR = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       pc_write;
        logic       ir_write;
        logic       a_write;
        logic       reg_write;
        logic       acc_write;
        logic [1:0] acc_src;
        logic       halted;
    } ctrl_t;

    // States that hold a memory request open until mem_ack.
    function automatic logic is_req_state(input logic [3:0] s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/sacc_ctrl_if.sv
// Control/memory handshake bundle between sacc_ctrl (master) and the
// datapath/memory side (slave).
interface sacc_ctrl_if #(parameter int CNT_W = 16) ();
    logic [3:0]       opcode;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             pc_write;
    logic             ir_write;
    logic             a_write;
    logic             reg_write;
    logic             acc_write;
    logic [1:0]       acc_src;
    logic             halted;
    logic             bus_err;
    logic             illegal;
    logic [CNT_W-1:0] inst_count;

    modport master (
        input  opcode, mem_ack,
        output mem_req, mem_write, iord, pc_write, ir_write, a_write,
               reg_write, acc_write, acc_src, halted, bus_err, illegal, inst_count
    );

    modport slave (
        output opcode, mem_ack,
        input  mem_req, mem_write, iord, pc_write, ir_write, a_write,
               reg_write, acc_write, acc_src, halted, bus_err, illegal, inst_count
    );
endinterface

// File: rtl/sacc_mem_timer.sv
// Memory wait counter: counts request cycles while enabled and flags the
// cycle in which the request has been outstanding for mem_timeout cycles.
module sacc_mem_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = enable && (count_reg == LIMIT);
endmodule

// File: rtl/sacc_ctrl.sv
// Multicycle fetch/decode/execute/writeback sequencer for the sacc
// accumulator datapath, with memory handshake timeout and retire counter.
module sacc_ctrl
    import sacc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    sacc_ctrl_if.master bus
);
    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] inst_count_reg;
    logic             bus_err_reg;
    logic             illegal_reg, illegal_next;
    logic             retire, timeout;
    logic             req_state, tmr_expired;
    ctrl_t            ctrl;

    assign req_state = is_req_state(state_reg);

    // A completed request or leaving the request states restarts the wait count,
    // which covers every entry into a request state.
    sacc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!req_state || bus.mem_ack),
        .enable  (req_state),
        .expired (tmr_expired)
    );

    always_comb begin
        state_next   = state_reg;
        retire       = 1'b0;
        timeout      = 1'b0;
        illegal_next = 1'b0;
        case (state_reg)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: if (bus.mem_ack) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_SACC: state_next = ST_WBREG;
                    OP_LACC,
                    OP_ADD:  state_next = ST_EXEC;
                    OP_LW:   state_next = ST_MEMRD;
                    OP_SW:   state_next = ST_MEMWR;
                    OP_HALT: state_next = ST_HALT;
                    default: begin
                        state_next   = ST_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            ST_WBREG, ST_EXEC, ST_MEMWB: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_MEMRD: if (bus.mem_ack) state_next = ST_MEMWB;
            ST_MEMWR: begin
                if (bus.mem_ack) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
        // An ack arriving in the expiry cycle still counts as normal progress.
        if (req_state && !bus.mem_ack && tmr_expired) begin
            state_next = ST_HALT;
            timeout    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            inst_count_reg <= '0;
            bus_err_reg    <= 1'b0;
            illegal_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
            if (retire)  inst_count_reg <= inst_count_reg + 1'b1;
            if (timeout) bus_err_reg    <= 1'b1;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_reg)
            ST_FETCH:  ctrl.mem_req = 1'b1;
            ST_LATCH: begin
                ctrl.ir_write = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            ST_DECODE: ctrl.a_write   = 1'b1;
            ST_WBREG:  ctrl.reg_write = 1'b1;
            ST_EXEC: begin
                ctrl.acc_write = 1'b1;
                ctrl.acc_src   = (bus.opcode == OP_ADD) ? ACC_SRC_SUM : ACC_SRC_A;
            end
            ST_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.acc_write = 1'b1;
                ctrl.acc_src   = ACC_SRC_MDR;
            end
            ST_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_HALT:   ctrl.halted = 1'b1;
            default:   ctrl = '0;
        endcase
    end

    assign bus.mem_req    = ctrl.mem_req;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.iord       = ctrl.iord;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.a_write    = ctrl.a_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.acc_write  = ctrl.acc_write;
    assign bus.acc_src    = ctrl.acc_src;
    assign bus.halted     = ctrl.halted;
    assign bus.bus_err    = bus_err_reg;
    assign bus.illegal    = illegal_reg;
    assign bus.inst_count = inst_count_reg;
endmodule

// File: tb/tb_sacc_ctrl.sv
// Scoreboard bench for sacc_ctrl: instruction-level model pushes expected
// control events, a negedge monitor pops and compares what the DUT shows.
module tb_sacc_ctrl;
    import sacc_ctrl_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_MASK    = (1 << CNT_W) - 1;

    localparam int EV_ILL  = 0;
    localparam int EV_MEM  = 1;
    localparam int EV_IR   = 2;
    localparam int EV_A    = 3;
    localparam int EV_REG  = 4;
    localparam int EV_ACC  = 5;
    localparam int EV_HALT = 6;

    typedef struct {
        int kind;
        int aux;
        int cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sacc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    sacc_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  model_cnt = 0;
    logic halted_prev = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic void push(input int kind, input int aux, input int cnt);
        ev_t e;
        e.kind = kind;
        e.aux  = aux;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endfunction

    // Instruction-level reference: the ordered control events one instruction produces.
    function automatic void model_instr(input logic [3:0] op);
        push(EV_MEM, 0, 0);
        push(EV_IR, 1, model_cnt);
        push(EV_A, 0, 0);
        case (op)
            4'b1111: push(EV_REG, 0, 0);
            4'b0001: push(EV_ACC, 0, 0);
            4'b0010: push(EV_ACC, 1, 0);
            4'b0011: begin push(EV_MEM, 2, 0); push(EV_ACC, 2, 0); end
            4'b0100: push(EV_MEM, 3, 0);
            4'b0000: push(EV_HALT, 0, 0);
            default: push(EV_ILL, 0, model_cnt);
        endcase
        if (op inside {4'b1111, 4'b0001, 4'b0010, 4'b0011, 4'b0100})
            model_cnt = (model_cnt + 1) & CNT_MASK;
    endfunction

    task automatic observe(input int kind, input int aux, input int cnt);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d aux=%0d cnt=%0d expected none", kind, aux, cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.aux != aux || e.cnt != cnt) begin
                n_bad++;
                $display("FAIL event @%0t: got kind=%0d aux=%0d cnt=%0d expected kind=%0d aux=%0d cnt=%0d",
                         $time, kind, aux, cnt, e.kind, e.aux, e.cnt);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                halted_prev = 1'b0;
            end else begin
                if (bus.illegal) observe(EV_ILL, 0, int'(bus.inst_count));
                if (bus.mem_req && bus.mem_ack) observe(EV_MEM, int'({bus.iord, bus.mem_write}), 0);
                if (bus.ir_write) observe(EV_IR, int'(bus.pc_write), int'(bus.inst_count));
                if (bus.a_write) observe(EV_A, 0, 0);
                if (bus.reg_write) observe(EV_REG, 0, 0);
                if (bus.acc_write) observe(EV_ACC, int'(bus.acc_src), 0);
                if (bus.halted && !halted_prev) observe(EV_HALT, int'(bus.bus_err), 0);
                halted_prev = bus.halted;
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_req) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("wait_mem_req_timeout", 0, 1);
    endtask

    // Hold off mem_ack for d request cycles, then ack; count request-high cycles.
    task automatic ack_phase(input int d, input logic [3:0] op, input string name);
        bit ok;
        int seen;
        seen = 0;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < d; i++) begin
            seen += int'(bus.mem_req);
            @(negedge clk);
        end
        seen += int'(bus.mem_req);
        bus.opcode  = op;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check(name, seen, d + 1);
    endtask

    task automatic run_instr(input logic [3:0] op, input int df, input int dd);
        model_instr(op);
        ack_phase(df, op, "fetch_req_cycles");
        if (op == OP_LW || op == OP_SW) ack_phase(dd, op, "data_req_cycles");
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.mem_ack = 1'b0;
        bus.opcode  = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_strobes", int'({bus.mem_req, bus.mem_write, bus.iord, bus.pc_write, bus.ir_write,
                                     bus.a_write, bus.reg_write, bus.acc_write, bus.acc_src,
                                     bus.halted, bus.bus_err, bus.illegal}), 0);
        check("reset_inst_count", int'(bus.inst_count), 0);
        exp_q.delete();
        model_cnt = 0;
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rand_op();
        int r;
        r = int'($urandom_range(0, 5));
        case (r)
            0: return OP_SACC;
            1: return OP_LACC;
            2: return OP_ADD;
            3: return OP_LW;
            4: return OP_SW;
            default: return 4'($urandom_range(5, 14));
        endcase
    endfunction

    function automatic int rand_delay();
        return ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int n;
        bus.opcode  = 4'b0000;
        bus.mem_ack = 1'b0;

        // SACC with no wait states, cycle by cycle after reset release.
        do_reset();
        model_instr(OP_SACC);
        @(negedge clk);
        check("sacc_cyc1_mem_req", int'(bus.mem_req), 1);
        bus.opcode  = OP_SACC;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("sacc_cyc2_ir_write", int'(bus.ir_write), 1);
        @(negedge clk);
        check("sacc_cyc3_a_write", int'(bus.a_write), 1);
        @(negedge clk);
        check("sacc_cyc4_reg_write", int'(bus.reg_write), 1);
        @(negedge clk);
        check("sacc_cyc5_inst_count", int'(bus.inst_count), 1);
        check("sacc_cyc5_mem_req", int'(bus.mem_req), 1);

        run_instr(OP_LW, 0, 3);
        run_instr(OP_LACC, MEM_TIMEOUT - 1, 0);
        run_instr(4'b1010, 0, 0);
        run_instr(OP_SW, 1, MEM_TIMEOUT - 1);

        for (int i = 0; i < 60; i++) run_instr(rand_op(), rand_delay(), rand_delay());

        run_instr(OP_HALT, 0, 0);
        repeat (5) @(negedge clk);
        check("halt_sticky", int'(bus.halted), 1);
        check("halt_no_req", int'(bus.mem_req), 0);
        check("halt_drained", exp_q.size(), 0);

        // Retire counter wrap in a CNT_W-bit build.
        do_reset();
        for (int i = 0; i < (1 << CNT_W); i++) run_instr(OP_ADD, 0, 0);
        wait_req(ok);
        check("inst_count_wrap", int'(bus.inst_count), 0);
        check("wrap_drained", exp_q.size(), 0);

        // Fetch never acknowledged: timeout into HALT with bus error.
        do_reset();
        push(EV_HALT, 1, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.halted) break;
            n += int'(bus.mem_req);
        end
        check("timeout_req_cycles", n, MEM_TIMEOUT);
        check("timeout_bus_err", int'(bus.bus_err), 1);
        bus.mem_ack = 1'b1;
        repeat (5) @(negedge clk);
        bus.mem_ack = 1'b0;
        check("timeout_halted_sticky", int'(bus.halted), 1);
        check("timeout_bus_err_sticky", int'(bus.bus_err), 1);
        check("timeout_no_req", int'(bus.mem_req), 0);
        check("timeout_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a store request.
        do_reset();
        run_instr(OP_LACC, 0, 0);
        run_instr(OP_SACC, 1, 0);
        model_instr(OP_SW);
        ack_phase(0, OP_SW, "sw_fetch_req_cycles");
        wait_req(ok);
        @(negedge clk);
        check("memwr_mem_write", int'(bus.mem_write), 1);
        check("memwr_count_before", int'(bus.inst_count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", int'(bus.mem_req), 0);
        check("async_rst_mem_write", int'(bus.mem_write), 0);
        check("async_rst_inst_count", int'(bus.inst_count), 0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_no_req", int'(bus.mem_req), 0);
        @(negedge clk);
        check("restart_fetch_req", int'(bus.mem_req), 1);
        check("restart_inst_count", int'(bus.inst_count), 0);

        check("final_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
